adc_in: RTL and testbench

Receive-side counterpart of the DAC output path. Accepts signed 14-bit ADC codes with a per-sample strobe, boxcar-averages 2^AVG_LOG2 samples, and converts the mean to the signed fixed-point voltage format used throughout the SPGD datapath (Q16.48 by default). The conversion scale is −20/16384 V/code, the exact inverse of the DAC code mapping. Results leave through a valid/ready handshake with a sticky overrun flag.

---
 rtl/adc_in.sv | 90 +++++++++
 tb/tb_adc_in.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_in.sv
// ADC receive path: boxcar-averages 2^AVG_LOG2 signed codes and converts the mean
// to a signed fixed-point voltage (-20/16384 V per code), delivered over valid/ready.
module adc_in #(
   parameter int FLOAT_WIDTH = 64,
   parameter int INT_WIDTH   = 16,
   parameter int ADC_WIDTH   = 14,
   parameter int AVG_LOG2    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [ADC_WIDTH-1:0]   adc_code_in,
   input  logic                          adc_valid_in,
   output logic signed [FLOAT_WIDTH-1:0] voltage_out,
   output logic                          voltage_valid,
   input  logic                          voltage_ready,
   output logic                          overrun
);

   localparam int FRAC = FLOAT_WIDTH - INT_WIDTH;
   localparam int AW   = ADC_WIDTH + AVG_LOG2;
   localparam int CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int PW   = ADC_WIDTH + 3;
   localparam int SH   = FRAC - (ADC_WIDTH - 2);
   localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum_next;
   logic signed [AW-1:0] s1_sum;
   logic [CW-1:0]        cnt;
   logic                 s1_valid;
   logic                 s2_valid;
   logic signed [PW-1:0] s2_p;
   logic                 window_end;
   logic signed [AW-1:0] mean_wide;
   logic signed [PW-1:0] mean_p;
   logic signed [PW-1:0] p_next;

   assign sum_next   = acc + AW'(adc_code_in);
   assign window_end = adc_valid_in && (cnt == LAST_CNT);

   // Floor-mean then scale by -5; the remaining 1/4096 is a pure binary shift at the output.
   always_comb begin
      mean_wide = s1_sum >>> AVG_LOG2;
      mean_p    = PW'(mean_wide);
      p_next    = -((mean_p <<< 2) + mean_p);
   end

   // Accumulator restarts on the same edge the window closes, so windows can abut.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         s1_sum   <= '0;
         s1_valid <= 1'b0;
         s2_p     <= '0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= window_end;
         if (adc_valid_in) begin
            if (window_end) begin
               acc    <= '0;
               cnt    <= '0;
               s1_sum <= sum_next;
            end else begin
               acc <= sum_next;
               cnt <= cnt + CW'(1);
            end
         end
         s2_valid <= s1_valid;
         if (s1_valid) s2_p <= p_next;
      end
   end

   // Handshake: a result transfers on any edge with voltage_valid && voltage_ready.
   // A new result always loads; if the held one was not taken that edge, overrun latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         voltage_out   <= '0;
         voltage_valid <= 1'b0;
         overrun       <= 1'b0;
      end else if (s2_valid) begin
         voltage_out   <= FLOAT_WIDTH'(s2_p) <<< SH;
         voltage_valid <= 1'b1;
         if (voltage_valid && !voltage_ready) overrun <= 1'b1;
      end else if (voltage_valid && voltage_ready) begin
         voltage_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_in.sv
// Directed bench for adc_in: one instance averaging 16 samples, one passing every sample.
module tb_adc_in;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [13:0] code0, code4;
   logic               valid0, valid4, ready0, ready4;
   logic [63:0]        v0, v4;
   logic               vv0, vv4, ov0, ov4;
   logic signed [13:0] win [16];
   int                 errors = 0;
   int                 checks = 0;

   always #5 clk = ~clk;

   adc_in #(.AVG_LOG2(4)) dut4 (
      .clk(clk), .rst(rst), .adc_code_in(code4), .adc_valid_in(valid4),
      .voltage_out(v4), .voltage_valid(vv4), .voltage_ready(ready4), .overrun(ov4)
   );

   adc_in #(.AVG_LOG2(0)) dut0 (
      .clk(clk), .rst(rst), .adc_code_in(code0), .adc_valid_in(valid0),
      .voltage_out(v0), .voltage_valid(vv0), .voltage_ready(ready0), .overrun(ov0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobes win[0..15] into dut4; returns one cycle after the last strobe.
   task automatic feed_window(input bit gapped);
      for (int i = 0; i < 16; i++) begin
         code4  = win[i];
         valid4 = 1'b1;
         tick();
         valid4 = 1'b0;
         if (gapped && i != 15) repeat (i % 3) tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (v4 !== 64'd0 || vv4 !== 1'b0 || ov4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut4: got out=%h valid=%b overrun=%b, expected 0/0/0", v4, vv4, ov4);
      end
      checks++;
      if (v0 !== 64'd0 || vv0 !== 1'b0 || ov0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut0: got out=%h valid=%b overrun=%b, expected 0/0/0", v0, vv0, ov0);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      ready0 = 1'b1;
      code0  = 14'sd1;
      valid0 = 1'b1;
      tick();
      valid0 = 1'b0;
      checks++;
      if (vv0 !== 1'b0) begin errors++; $display("FAIL latency_n1: valid=%b expected 0", vv0); end
      tick();
      checks++;
      if (vv0 !== 1'b0) begin errors++; $display("FAIL latency_n2: valid=%b expected 0", vv0); end
      tick();
      checks++;
      if (vv0 !== 1'b1 || v0 !== 64'hFFFF_FFB0_0000_0000) begin
         errors++;
         $display("FAIL latency_n3: got valid=%b out=%h, expected 1 ffffffb000000000", vv0, v0);
      end
      tick();
      checks++;
      if (vv0 !== 1'b0) begin errors++; $display("FAIL latency_drain: valid=%b expected 0", vv0); end
   endtask

   task automatic test_full_scale();
      ready4 = 1'b1;
      for (int i = 0; i < 16; i++) win[i] = -14'sd8192;
      feed_window(1'b1);
      checks++;
      if (vv4 !== 1'b0) begin errors++; $display("FAIL full_scale_early: valid=%b expected 0", vv4); end
      tick();
      checks++;
      if (vv4 !== 1'b0) begin errors++; $display("FAIL full_scale_n2: valid=%b expected 0", vv4); end
      tick();
      checks++;
      if (vv4 !== 1'b1 || v4 !== 64'h000A_0000_0000_0000) begin
         errors++;
         $display("FAIL full_scale: got valid=%b out=%h, expected 1 000a000000000000", vv4, v4);
      end
      tick();
      checks++;
      if (vv4 !== 1'b0) begin errors++; $display("FAIL full_scale_one_cycle: valid=%b expected 0", vv4); end
   endtask

   task automatic test_conversion();
      logic [63:0] exp_tab [3];
      exp_tab[0] = 64'h0000_0050_0000_0000;  // alternating +3/-4, mean floors to -1
      exp_tab[1] = 64'h0000_0000_0000_0000;  // all zero
      exp_tab[2] = 64'hFFF6_0050_0000_0000;  // all +8191
      ready4 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) begin
            if (k == 0)      win[i] = (i % 2 == 0) ? 14'sd3 : -14'sd4;
            else if (k == 1) win[i] = 14'sd0;
            else             win[i] = 14'sd8191;
         end
         feed_window(1'b0);
         tick();
         tick();
         checks++;
         if (vv4 !== 1'b1 || v4 !== exp_tab[k]) begin
            errors++;
            $display("FAIL conversion_%0d: got valid=%b out=%h, expected 1 %h", k, vv4, v4, exp_tab[k]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      ready0 = 1'b0;
      code0  = 14'sd1;
      valid0 = 1'b1;
      tick();
      code0 = 14'sd2;
      tick();
      valid0 = 1'b0;
      tick();
      checks++;
      if (vv0 !== 1'b1 || v0 !== 64'hFFFF_FFB0_0000_0000) begin
         errors++;
         $display("FAIL b2b_first: got valid=%b out=%h, expected 1 ffffffb000000000", vv0, v0);
      end
      ready0 = 1'b1;
      tick();
      checks++;
      if (vv0 !== 1'b1 || v0 !== 64'hFFFF_FF60_0000_0000 || ov0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got valid=%b out=%h overrun=%b, expected 1 ffffff6000000000 0", vv0, v0, ov0);
      end
      tick();
      checks++;
      if (vv0 !== 1'b0 || ov0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got valid=%b overrun=%b, expected 0 0", vv0, ov0);
      end
   endtask

   task automatic test_overrun();
      ready0 = 1'b0;
      valid0 = 1'b1;
      code0  = 14'sd1;
      tick();
      code0 = 14'sd2;
      tick();
      code0 = 14'sd3;
      tick();
      valid0 = 1'b0;
      checks++;
      if (vv0 !== 1'b1 || v0 !== 64'hFFFF_FFB0_0000_0000 || ov0 !== 1'b0) begin
         errors++;
         $display("FAIL overrun_first: got valid=%b out=%h overrun=%b, expected 1 ffffffb000000000 0", vv0, v0, ov0);
      end
      tick();
      tick();
      tick();
      checks++;
      if (vv0 !== 1'b1 || v0 !== 64'hFFFF_FF10_0000_0000 || ov0 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_hold: got valid=%b out=%h overrun=%b, expected 1 ffffff1000000000 1", vv0, v0, ov0);
      end
      ready0 = 1'b1;
      tick();
      checks++;
      if (vv0 !== 1'b0 || ov0 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky: got valid=%b overrun=%b, expected 0 1", vv0, ov0);
      end
   endtask

   task automatic test_reset_mid_window();
      int early;
      ready4 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         code4  = 14'sd50;
         valid4 = 1'b1;
         tick();
         valid4 = 1'b0;
      end
      rst    = 1'b1;
      valid4 = 1'b1;          // strobe coincident with reset must be dropped
      code4  = -14'sd8192;
      tick();
      checks++;
      if (v4 !== 64'd0 || vv4 !== 1'b0 || ov4 !== 1'b0 || v0 !== 64'd0 || vv0 !== 1'b0 || ov0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got out4=%h v4=%b o4=%b out0=%h v0=%b o0=%b, expected all 0",
                  v4, vv4, ov4, v0, vv0, ov0);
      end
      rst    = 1'b0;
      valid4 = 1'b0;
      for (int i = 0; i < 16; i++) win[i] = 14'sd7;
      feed_window(1'b0);
      tick();
      rst = 1'b1;             // result currently sits in stage 2
      tick();
      rst = 1'b0;
      early = 0;
      for (int i = 0; i < 5; i++) begin
         if (vv4 !== 1'b0) early++;
         tick();
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL reset_flush: got %0d valid cycles, expected 0", early);
      end
      for (int i = 0; i < 16; i++) win[i] = 14'sd100;
      feed_window(1'b0);
      tick();
      checks++;
      if (vv4 !== 1'b0) begin errors++; $display("FAIL post_reset_early: valid=%b expected 0", vv4); end
      tick();
      checks++;
      if (vv4 !== 1'b1 || v4 !== 64'hFFFF_E0C0_0000_0000) begin
         errors++;
         $display("FAIL post_reset_result: got valid=%b out=%h, expected 1 ffffe0c000000000", vv4, v4);
      end
      tick();
      checks++;
      if (vv4 !== 1'b0) begin errors++; $display("FAIL post_reset_one_cycle: valid=%b expected 0", vv4); end
   endtask

   initial begin
      rst    = 1'b1;
      code0  = '0;
      code4  = '0;
      valid0 = 1'b0;
      valid4 = 1'b0;
      ready0 = 1'b0;
      ready4 = 1'b0;
      test_reset();
      test_latency();
      test_full_scale();
      test_conversion();
      test_back_to_back();
      test_overrun();
      test_reset_mid_window();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
